// File: rtl/cronometro_pkg.sv
//==============================================================================
// Module      : cronometro_pkg
// Description : Shared pin indices and default conditioning masks for the
//               stopwatch input conditioner.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package cronometro_pkg;

    localparam int IDX_MODE0  = 0;
    localparam int IDX_MODE1  = 1;
    localparam int IDX_PAUSE  = 2;
    localparam int IDX_PIO_SW = 3;
    localparam int IDX_PLAY   = 4;
    localparam int N_INPUTS   = 5;

    localparam int                    DEBOUNCE_CYCLES_DEF   = 500_000;
    // The play key idles high on the board; switches are active-high.
    localparam logic [N_INPUTS-1:0]   ACTIVE_LOW_MASK_DEF   = 5'b10000;
    // Switches report both edges so firmware sees every mode change.
    localparam logic [N_INPUTS-1:0]   CAPTURE_FALL_MASK_DEF = 5'b01111;

endpackage : cronometro_pkg

`default_nettype wire

// File: rtl/debounce_bit.sv
//==============================================================================
// Module      : debounce_bit
// Description : One input lane: 2-flop synchronizer, polarity fix, counter
//               debounce and registered one-cycle rise/fall pulses.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module debounce_bit #(
    parameter int DEBOUNCE_CYCLES = 500_000,
    parameter bit ACTIVE_LOW      = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int               CNT_W   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             sync1_q;
    logic             sync2_q;
    logic             norm_w;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             level_q;
    logic             level_d;
    logic             level_dly_q;
    logic             rise_q;
    logic             fall_q;

    assign norm_w = sync2_q ^ ACTIVE_LOW;

    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        if (norm_w == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            level_d = norm_w;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    // Pulses follow the level register by one cycle so they never overlap
    // the cycle in which level_o itself changes.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            cnt_q       <= '0;
            level_q     <= 1'b0;
            level_dly_q <= 1'b0;
            rise_q      <= 1'b0;
            fall_q      <= 1'b0;
        end else begin
            sync1_q     <= raw_i;
            sync2_q     <= sync1_q;
            cnt_q       <= cnt_d;
            level_q     <= level_d;
            level_dly_q <= level_q;
            rise_q      <= level_q & ~level_dly_q;
            fall_q      <= ~level_q & level_dly_q;
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule : debounce_bit

`default_nettype wire

// File: rtl/cronometro_input_conditioner.sv
//==============================================================================
// Module      : cronometro_input_conditioner
// Description : Conditions raw board switches/keys into debounced levels,
//               edge pulses, sticky edge flags and a maskable interrupt.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module cronometro_input_conditioner #(
    parameter int                                    N_INPUTS          = cronometro_pkg::N_INPUTS,
    parameter int                                    DEBOUNCE_CYCLES   = cronometro_pkg::DEBOUNCE_CYCLES_DEF,
    parameter logic [cronometro_pkg::N_INPUTS-1:0]   ACTIVE_LOW_MASK   = cronometro_pkg::ACTIVE_LOW_MASK_DEF,
    parameter logic [cronometro_pkg::N_INPUTS-1:0]   CAPTURE_FALL_MASK = cronometro_pkg::CAPTURE_FALL_MASK_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [N_INPUTS-1:0] raw_in,
    input  logic [N_INPUTS-1:0] irq_mask,
    input  logic [N_INPUTS-1:0] clear_capture,
    output logic [N_INPUTS-1:0] level_out,
    output logic [N_INPUTS-1:0] rise_pulse,
    output logic [N_INPUTS-1:0] fall_pulse,
    output logic [N_INPUTS-1:0] edge_capture,
    output logic                irq
);

    import cronometro_pkg::*;

    logic [N_INPUTS-1:0] capture_q;
    logic [N_INPUTS-1:0] capture_d;
    logic [N_INPUTS-1:0] fall_mask_w;

    assign fall_mask_w = N_INPUTS'(CAPTURE_FALL_MASK);

    for (genvar i = 0; i < N_INPUTS; i++) begin : g_bit
        debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .ACTIVE_LOW      (ACTIVE_LOW_MASK[i])
        ) u_debounce (
            .clk     (clk),
            .reset   (reset),
            .raw_i   (raw_in[i]),
            .level_o (level_out[i]),
            .rise_o  (rise_pulse[i]),
            .fall_o  (fall_pulse[i])
        );
    end

    // Set terms are OR-ed after the clear so a coincident edge is never lost.
    always_comb begin
        capture_d = (capture_q & ~clear_capture)
                  | rise_pulse
                  | (fall_pulse & fall_mask_w);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            capture_q <= '0;
        end else begin
            capture_q <= capture_d;
        end
    end

    assign edge_capture = capture_q;
    assign irq          = |(capture_q & irq_mask);

endmodule : cronometro_input_conditioner

`default_nettype wire

// File: tb/tb_cronometro_input_conditioner.sv
//==============================================================================
// Module      : tb_cronometro_input_conditioner
// Description : Directed, table-driven bench for the input conditioner with
//               DEBOUNCE_CYCLES = 4.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_cronometro_input_conditioner;

    localparam int N       = 5;
    localparam int N_ROWS  = 25;

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] raw_in;
    logic [N-1:0] irq_mask;
    logic [N-1:0] clear_capture;
    logic [N-1:0] level_out;
    logic [N-1:0] rise_pulse;
    logic [N-1:0] fall_pulse;
    logic [N-1:0] edge_capture;
    logic         irq;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [N-1:0] raw;
        logic [N-1:0] mask;
        logic [N-1:0] clr;
        logic [N-1:0] lvl;
        logic [N-1:0] rise;
        logic [N-1:0] fall;
        logic [N-1:0] cap;
        logic         irq;
    } vec_t;

    vec_t tbl [N_ROWS];

    cronometro_input_conditioner #(
        .N_INPUTS          (N),
        .DEBOUNCE_CYCLES   (4),
        .ACTIVE_LOW_MASK   (5'b10000),
        .CAPTURE_FALL_MASK (5'b01111)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .raw_in        (raw_in),
        .irq_mask      (irq_mask),
        .clear_capture (clear_capture),
        .level_out     (level_out),
        .rise_pulse    (rise_pulse),
        .fall_pulse    (fall_pulse),
        .edge_capture  (edge_capture),
        .irq           (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_all_zero(input string name);
        check({name, ".level"}, 32'(level_out), 32'h0);
        check({name, ".rise"},  32'(rise_pulse), 32'h0);
        check({name, ".fall"},  32'(fall_pulse), 32'h0);
        check({name, ".cap"},   32'(edge_capture), 32'h0);
        check({name, ".irq"},   32'(irq), 32'h0);
    endtask

    initial begin
        // Row j drives inputs in cycle j; expectations are for cycle j+1.
        // Bit 0 steps high at cycle 10 (level at 16, rise at 17, capture from 18);
        // bit 2 glitches high for cycles 18..20; play key held released.
        for (int j = 0; j < N_ROWS; j++) begin
            tbl[j].raw  = 5'b10000 | ((j >= 10) ? 5'b00001 : 5'b00000)
                                   | ((j >= 18 && j <= 20) ? 5'b00100 : 5'b00000);
            tbl[j].mask = 5'b10000;
            tbl[j].clr  = 5'b00000;
            tbl[j].lvl  = (j >= 15) ? 5'b00001 : 5'b00000;
            tbl[j].rise = (j == 16) ? 5'b00001 : 5'b00000;
            tbl[j].fall = 5'b00000;
            tbl[j].cap  = (j >= 17) ? 5'b00001 : 5'b00000;
            tbl[j].irq  = 1'b0;
        end

        reset         = 1'b1;
        raw_in        = 5'b10000;
        irq_mask      = 5'b00000;
        clear_capture = 5'b00000;
        tick(3);
        check_all_zero("reset");
        reset = 1'b0;

        for (int j = 0; j < N_ROWS; j++) begin
            raw_in        = tbl[j].raw;
            irq_mask      = tbl[j].mask;
            clear_capture = tbl[j].clr;
            tick(1);
            check($sformatf("row%0d.level", j), 32'(level_out), 32'(tbl[j].lvl));
            check($sformatf("row%0d.rise", j),  32'(rise_pulse), 32'(tbl[j].rise));
            check($sformatf("row%0d.fall", j),  32'(fall_pulse), 32'(tbl[j].fall));
            check($sformatf("row%0d.cap", j),   32'(edge_capture), 32'(tbl[j].cap));
            check($sformatf("row%0d.irq", j),   32'(irq), 32'(tbl[j].irq));
        end

        // Active-low play key press and release.
        raw_in = 5'b00001;
        tick(5);
        check("key.level_early", 32'(level_out), 32'h01);
        tick(1);
        check("key.level_on", 32'(level_out), 32'h11);
        tick(1);
        check("key.rise", 32'(rise_pulse), 32'h10);
        check("key.fall_quiet", 32'(fall_pulse), 32'h00);
        tick(1);
        check("key.rise_done", 32'(rise_pulse), 32'h00);
        check("key.cap", 32'(edge_capture), 32'h11);
        check("key.irq_on", 32'(irq), 32'h1);
        clear_capture = 5'b10000;
        tick(1);
        clear_capture = 5'b00000;
        check("key.cap_cleared", 32'(edge_capture), 32'h01);
        check("key.irq_off", 32'(irq), 32'h0);
        raw_in = 5'b10001;
        tick(6);
        check("key.level_off", 32'(level_out), 32'h01);
        tick(1);
        check("key.fall", 32'(fall_pulse), 32'h10);
        check("key.rise_quiet", 32'(rise_pulse), 32'h00);
        tick(1);
        check("key.no_fall_cap", 32'(edge_capture), 32'h01);
        check("key.irq_still_off", 32'(irq), 32'h0);

        // A switch falling edge does set its capture flag.
        clear_capture = 5'b00001;
        tick(1);
        clear_capture = 5'b00000;
        check("sw.cap_cleared", 32'(edge_capture), 32'h00);
        raw_in = 5'b10000;
        tick(7);
        check("sw.fall", 32'(fall_pulse), 32'h01);
        tick(1);
        check("sw.fall_cap", 32'(edge_capture), 32'h01);
        clear_capture = 5'b00001;
        tick(1);
        clear_capture = 5'b00000;

        // Clear coinciding with a set: the set wins; a later lone clear wins.
        raw_in = 5'b10010;
        tick(7);
        check("cs.rise", 32'(rise_pulse), 32'h02);
        clear_capture = 5'b00010;
        tick(1);
        clear_capture = 5'b00000;
        check("cs.set_wins", 32'(edge_capture), 32'h02);
        clear_capture = 5'b00010;
        tick(1);
        clear_capture = 5'b00000;
        check("cs.clear_alone", 32'(edge_capture), 32'h00);

        // Reset with bit 3 two counts into its debounce.
        raw_in = 5'b11000;
        tick(4);
        reset = 1'b1;
        tick(1);
        check_all_zero("midrst");
        reset = 1'b0;
        tick(5);
        check("midrst.level_early", 32'(level_out), 32'h00);
        tick(1);
        check("midrst.level_on", 32'(level_out), 32'h08);
        tick(1);
        check("midrst.rise", 32'(rise_pulse), 32'h08);
        tick(1);
        check("midrst.cap", 32'(edge_capture), 32'h08);
        check("midrst.irq", 32'(irq), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_cronometro_input_conditioner

`default_nettype wire
